// File: rtl/display_page_sequencer.sv
// ----------------------------------------------------------------------------
// display_page_sequencer
//
// Selects which page of the 32-bit hex debug display mux is shown. Two raw
// active-low pushbuttons step the page forward/backward (after synchronizing
// and debouncing), and an optional auto-scroll timer steps it forward at a
// fixed interval. Every page change blanks the display for BLANK_CYCLES
// cycles as visual feedback.
//
// Ports
//   Clock           in   system clock, all state updates on the rising edge
//   Reset_n         in   synchronous active-low reset
//   Next_Btn_n      in   raw pushbutton (active low, asynchronous), page +1
//   Prev_Btn_n      in   raw pushbutton (active low, asynchronous), page -1
//   Auto_Mode       in   switch, 1 = auto-scroll enabled
//   Display_Select  out  page index 0..NUM_PAGES-1 for the display mux
//   Display_Enable  out  1 = display blanked, 0 = selected page shown
//   Page_Changed    out  one-cycle pulse in the cycle Display_Select changes
// ----------------------------------------------------------------------------
module display_page_sequencer #(
    parameter int NUM_PAGES       = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCROLL_CYCLES   = 50000000,
    parameter int BLANK_CYCLES    = 5000000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Next_Btn_n,
    input  logic       Prev_Btn_n,
    input  logic       Auto_Mode,
    output logic [4:0] Display_Select,
    output logic       Display_Enable,
    output logic       Page_Changed
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SC_W = $clog2(SCROLL_CYCLES);
    localparam int BL_W = $clog2(BLANK_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(SCROLL_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST   = BL_W'(BLANK_CYCLES - 1);
    localparam logic [4:0]      PAGE_LAST = 5'(NUM_PAGES - 1);

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    // Index 0 = Next button, index 1 = Prev button.
    logic [1:0] raw_btn;
    logic [1:0] press_evt;

    assign raw_btn = {Prev_Btn_n, Next_Btn_n};

    // ------------------------------------------------------------------
    // Button synchronizer + debouncer, one instance per button
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic [DB_W-1:0] cnt_reg;
            logic            settle;

            // The synchronized level has disagreed long enough: the
            // debounced level takes the new value at this edge.
            assign settle = (sync2_reg != level_reg) && (cnt_reg == DB_LAST);

            // A press is the debounced level going 1->0. The event is
            // flagged in the cycle the transition is committed so the page
            // step lands on the same edge as the level update.
            assign press_evt[gi] = settle && level_reg;

            always_ff @(posedge Clock) begin
                if (!Reset_n) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    level_reg <= 1'b1;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_btn[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != level_reg) begin
                        if (settle) begin
                            level_reg <= sync2_reg;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Auto-scroll switch synchronizer and interval counter
    // ------------------------------------------------------------------
    logic            auto_s1_reg;
    logic            auto_s2_reg;
    logic [SC_W-1:0] scroll_cnt_reg;
    logic            auto_tick;
    logic            manual_step;
    logic            step_up;
    logic            step_down;
    logic            step;

    assign auto_tick   = auto_s2_reg && (scroll_cnt_reg == SC_LAST);
    // Both buttons in the same cycle cancel each other and also suppress
    // any auto tick of that cycle.
    assign manual_step = press_evt[0] ^ press_evt[1];
    assign step_up     = (press_evt[0] && !press_evt[1]) ||
                         (!press_evt[0] && !press_evt[1] && auto_tick);
    assign step_down   = press_evt[1] && !press_evt[0];
    assign step        = step_up || step_down;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            auto_s1_reg    <= 1'b0;
            auto_s2_reg    <= 1'b0;
            scroll_cnt_reg <= '0;
        end else begin
            auto_s1_reg <= Auto_Mode;
            auto_s2_reg <= auto_s1_reg;
            // Clearing while disabled means re-enabling restarts a full
            // interval; a manual step also restarts the interval.
            if (!auto_s2_reg || auto_tick || manual_step) begin
                scroll_cnt_reg <= '0;
            end else begin
                scroll_cnt_reg <= scroll_cnt_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Page select / blanking FSM
    // ------------------------------------------------------------------
    state_t          state_reg;
    logic [4:0]      select_reg;
    logic            enable_reg;
    logic            changed_reg;
    logic [BL_W-1:0] blank_cnt_reg;
    logic [4:0]      select_next;

    always_comb begin
        select_next = select_reg;
        if (step_up) begin
            select_next = (select_reg == PAGE_LAST) ? 5'd0 : select_reg + 5'd1;
        end else if (step_down) begin
            select_next = (select_reg == 5'd0) ? PAGE_LAST : select_reg - 5'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_reg     <= SHOW;
            select_reg    <= 5'd0;
            enable_reg    <= 1'b0;
            changed_reg   <= 1'b0;
            blank_cnt_reg <= '0;
        end else if (step) begin
            // A step is honoured in either state; in BLANK it restarts
            // the blanking window.
            state_reg     <= BLANK;
            select_reg    <= select_next;
            enable_reg    <= 1'b1;
            changed_reg   <= 1'b1;
            blank_cnt_reg <= '0;
        end else begin
            changed_reg <= 1'b0;
            case (state_reg)
                SHOW: begin
                    enable_reg    <= 1'b0;
                    blank_cnt_reg <= '0;
                end
                BLANK: begin
                    if (blank_cnt_reg == BL_LAST) begin
                        state_reg     <= SHOW;
                        enable_reg    <= 1'b0;
                        blank_cnt_reg <= '0;
                    end else begin
                        enable_reg    <= 1'b1;
                        blank_cnt_reg <= blank_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg     <= SHOW;
                    enable_reg    <= 1'b0;
                    blank_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign Display_Select = select_reg;
    assign Display_Enable = enable_reg;
    assign Page_Changed   = changed_reg;

endmodule
